// File: rtl/fnd_pkg.sv
// Shared types and constants for the multiplexed FND scan controller.
package fnd_pkg;

  typedef enum logic {
    SHOW       = 1'b0,
    GUARD_SLOT = 1'b1
  } scan_state_t;

  localparam int unsigned DIG_W   = 4;
  localparam logic [31:0] DIG_OFF = '1;

endpackage

// File: rtl/fnd_scan_if.sv
// Data-load and display-drive signals of the FND scan controller.
interface fnd_scan_if #(
  parameter int unsigned DIGITS = 4
);
  import fnd_pkg::*;

  logic                      load;
  logic [DIG_W*DIGITS-1:0]   data_in;
  logic [DIG_W-1:0]          number;
  logic [DIGITS-1:0]         digit_sel;
  logic                      frame_start;

  modport master (output load, data_in, input number, digit_sel, frame_start);
  modport slave  (input load, data_in, output number, digit_sel, frame_start);

endinterface

// File: rtl/fnd_scan_timer.sv
// Slot timer: counts lit cycles and guard cycles, flags slot ends and frame wraps.
module fnd_scan_timer
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        last_digit,
  output scan_state_t state,
  output logic        slot_first,
  output logic        slot_end,
  output logic        wrap
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = (GUARD == 0) ? '0 : CW'(GUARD - 1);

  scan_state_t   state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SHOW;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    slot_end = 1'b0;
    unique case (state)
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_nx = '0;
          // With no guard interval the slot ends straight out of SHOW.
          if (GUARD == 0) slot_end = 1'b1;
          else            state_nx = GUARD_SLOT;
        end
      end
      GUARD_SLOT: begin
        if (cnt == GUARD_LAST) begin
          cnt_nx   = '0;
          slot_end = 1'b1;
          state_nx = SHOW;
        end
      end
    endcase
  end

  assign slot_first = (state == SHOW) && (cnt == '0);
  assign wrap       = slot_end && last_digit;

endmodule

// File: rtl/fnd_scan.sv
// Multiplexed 7-segment scan controller with tear-free frame updates.
// Optional leading-zero blanking when FND_LZB_EN is defined.
module fnd_scan
  import fnd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 8
) (
  input  logic        clk,
  input  logic        rst,
  fnd_scan_if.slave   bus
);

  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned DW = DIG_W * DIGITS;
  localparam logic [DIGITS-1:0] SEL_OFF = DIG_OFF[DIGITS-1:0];

  scan_state_t       state;
  logic              slot_first, slot_end, wrap, last_digit;
  logic [IW-1:0]     idx;
  logic [DW-1:0]     disp, shadow;
  logic              pending;
  logic [DIG_W-1:0]  cur_code;
  logic [DIGITS-1:0] lit_mask, sel_on;

  assign last_digit = (idx == IW'(DIGITS - 1));

  fnd_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .last_digit (last_digit),
    .state      (state),
    .slot_first (slot_first),
    .slot_end   (slot_end),
    .wrap       (wrap)
  );

  assign cur_code = disp[DIG_W*idx +: DIG_W];

`ifdef FND_LZB_EN
  // A digit stays lit once any digit at or above it is nonzero; digit 0 always lit.
  always_comb begin
    logic seen;
    seen        = 1'b0;
    lit_mask    = '0;
    lit_mask[0] = 1'b1;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      seen        = seen | (disp[DIG_W*k +: DIG_W] != '0);
      lit_mask[k] = seen;
    end
  end
`else
  assign lit_mask = '1;
`endif

  always_comb begin
    sel_on      = SEL_OFF;
    sel_on[idx] = ~lit_mask[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= '0;
      disp            <= '0;
      shadow          <= '0;
      pending         <= 1'b0;
      bus.number      <= '0;
      bus.digit_sel   <= SEL_OFF;
      bus.frame_start <= 1'b0;
    end else begin
      if (slot_end) idx <= last_digit ? '0 : idx + IW'(1);

      if (bus.load) shadow <= bus.data_in;
      // A load coinciding with the wrap bypasses the shadow and leaves nothing queued.
      if (wrap) begin
        pending <= 1'b0;
        if (bus.load)    disp <= bus.data_in;
        else if (pending) disp <= shadow;
      end else if (bus.load) begin
        pending <= 1'b1;
      end

      bus.frame_start <= slot_first && (idx == '0);
      if (state == SHOW) begin
        bus.number    <= cur_code;
        bus.digit_sel <= sel_on;
      end else begin
        bus.digit_sel <= SEL_OFF;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan.sv
// Directed bench for fnd_scan with DIGITS=4, SCAN_DIV=4, GUARD=1 (20-cycle frame).
module tb_fnd_scan;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned GUARD    = 1;
  localparam int unsigned NV       = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fnd_scan_if #(.DIGITS(DIGITS)) bus ();

  fnd_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [15:0] data;
    logic [3:0]  sel;
    logic [3:0]  num;
    logic        fs;
  } vec_t;

  vec_t        vec [NV];
  logic [15:0] frame_data [5];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] shown;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit lit_digit(input logic [15:0] d, input int unsigned slot);
`ifdef FND_LZB_EN
    if (slot == 0) return 1'b1;
    return (d >> (4 * slot)) != 16'h0;
`else
    return 1'b1;
`endif
  endfunction

  // Frame position pos: slot = pos/5, cycles 0..3 of a slot lit, cycle 4 dark.
  function automatic logic [3:0] exp_num(input logic [15:0] fd, input int unsigned pos);
    logic [15:0] t;
    t = fd >> (4 * (pos / 5));
    return t[3:0];
  endfunction

  function automatic logic [3:0] exp_sel(input logic [15:0] fd, input int unsigned pos);
    logic [3:0] one;
    one = 4'b0001;
    if (pos % 5 == 4 || !lit_digit(fd, pos / 5)) return 4'hF;
    return ~(one << (pos / 5));
  endfunction

  task automatic step_chk(input int unsigned pos, input logic [15:0] fd, input string tag);
    @(posedge clk); #1;
    chk($sformatf("%s.sel@%0d", tag, pos), 16'(bus.digit_sel), 16'(exp_sel(fd, pos)));
    chk($sformatf("%s.num@%0d", tag, pos), 16'(bus.number), 16'(exp_num(fd, pos)));
    chk($sformatf("%s.fs@%0d", tag, pos), 16'(bus.frame_start), 16'(pos == 0));
  endtask

  task automatic lzb_case(input logic [15:0] d, input logic [3:0] exp_mask);
    logic [3:0] seen;
    seen = 4'h0;
    for (int unsigned p = 0; p < 20; p++) begin
      bus.load    = (p == 0);
      bus.data_in = d;
      step_chk(p, shown, "lzb_old");
    end
    bus.load = 1'b0;
    for (int unsigned p = 0; p < 20; p++) begin
      step_chk(p, d, "lzb_new");
      seen = seen | ~bus.digit_sel;
    end
    chk($sformatf("lzb_mask_%h", d), 16'(seen), 16'(exp_mask));
    shown = d;
  endtask

  initial begin
    int unsigned f;
    int unsigned pos;

    bus.load    = 1'b0;
    bus.data_in = '0;
    frame_data  = '{16'h0000, 16'h1234, 16'hABCD, 16'h5678, 16'h5678};

    // Edge k+1 after reset release; loads of 1234, ABCD (digit 2 lit), 5678 (wrap edge).
    for (int k = 0; k < NV; k++) begin
      f   = k / 20;
      pos = k % 20;
      vec[k].load = (k == 0) || (k == 31) || (k == 59);
      vec[k].data = (k == 0) ? 16'h1234 : (k == 31) ? 16'hABCD :
                    (k == 59) ? 16'h5678 : 16'hFFFF;
      vec[k].sel  = exp_sel(frame_data[f], pos);
      vec[k].num  = exp_num(frame_data[f], pos);
      vec[k].fs   = (pos == 0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset.sel", 16'(bus.digit_sel), 16'h000F);
    chk("reset.num", 16'(bus.number), 16'h0000);
    chk("reset.fs", 16'(bus.frame_start), 16'h0000);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      bus.load    = vec[k].load;
      bus.data_in = vec[k].data;
      @(posedge clk); #1;
      chk($sformatf("vec.sel[%0d]", k), 16'(bus.digit_sel), 16'(vec[k].sel));
      chk($sformatf("vec.num[%0d]", k), 16'(bus.number), 16'(vec[k].num));
      chk($sformatf("vec.fs[%0d]", k), 16'(bus.frame_start), 16'(vec[k].fs));
    end
    bus.load = 1'b0;

    // Queue a load during digit 2, then reset mid-cycle: the queued data must be lost.
    for (int unsigned p = 0; p < 12; p++) begin
      bus.load    = (p == 10);
      bus.data_in = 16'h9999;
      step_chk(p, 16'h5678, "pre_rst");
    end
    bus.load = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst.sel", 16'(bus.digit_sel), 16'h000F);
    chk("async_rst.num", 16'(bus.number), 16'h0000);
    chk("async_rst.fs", 16'(bus.frame_start), 16'h0000);
    @(posedge clk); #1;
    chk("held_rst.sel", 16'(bus.digit_sel), 16'h000F);
    rst = 1'b0;
    for (int unsigned p = 0; p < 40; p++) step_chk(p % 20, 16'h0000, "post_rst");
    shown = 16'h0000;

`ifdef FND_LZB_EN
    lzb_case(16'h0050, 4'b0011);
    lzb_case(16'h0000, 4'b0001);
    lzb_case(16'h1000, 4'b1111);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
